video_timing_decoder: RTL and testbench
=======================================

// Module: video_timing_decoder
// PURPOSE
// Receive-side counterpart of the video timing generator. Samples an incoming hsync/vsync/de
// stream clocked by the pixel clock and recovers per-pixel x/y coordinates. Measures line and
// frame geometry and asserts locked once the geometry is stable across frames. Sits at a video
// input or loopback port, ahead of capture/scaler logic.
// PARAMETERS
// H_SYNC_ACTIVE  1'b1    level of hsync meaning "in sync"
// V_SYNC_ACTIVE  1'b1    level of vsync meaning "in sync"
// LOCK_FRAMES    2       consecutive matching frame measurements required for locked
// TIMEOUT_CLKS   16'd4096  clocks without an hsync leading edge before lock is dropped
// PORTS
// clk           in   1   pixel clock; all logic on posedge
// reset_n       in   1   asynchronous, active-low reset
// hsync         in   1   incoming horizontal sync, synchronous to clk
// vsync         in   1   incoming vertical sync, synchronous to clk
// de            in   1   incoming data-enable (visible pixel)
// x             out  16  index of current visible pixel in line, 0 when !visible
// y             out  16  index of current visible line in frame, 0 when !visible
// visible       out  1   de delayed to align with x/y
// line_start    out  1   1-cycle pulse at each hsync leading edge
// frame_start   out  1   1-cycle pulse at each vsync leading edge
// h_total       out  16  clocks per line (leading edge to leading edge), last frame
// h_active      out  16  de clocks in last line that had de, last frame
// v_total       out  16  lines per frame, last frame
// v_active      out  16  lines containing de, last frame
// locked        out  1   geometry stable for LOCK_FRAMES consecutive comparisons
// BEHAVIOUR
// - Reset (async, reset_n=0): all outputs 0, all counters/flags 0, match_cnt 0, FSM UNLOCKED.
// - Stage 1: register hsync/vsync/de; hs_a=s_hs~^H_SYNC_ACTIVE, vs_a likewise; keep prev copy.
//   hs_rise=hs_a&~hs_a_prev; vs_rise similar; de_fall=s_de_prev&~s_de.
// - Stage 2 (outputs): all outputs registered; latency 2 clks from input pin to x/y/visible/pulses.
// - h_cnt: hs_rise -> 1, else saturating +1 (holds 16'hFFFF). hs_rise latches h_total_cur=h_cnt.
// - de_cnt: cleared on hs_rise; +1 (saturating) each s_de cycle. x=de_cnt value before increment.
//   On de_fall, h_active_last<=de_cnt and v_act_cnt +1 (saturating).
// - v_cnt: +1 per hs_rise. On vs_rise: v_total_cur=v_cnt; v_cnt<=hs_rise?1:0 (coincident hsync
//   edge belongs to the new frame). v_act_cnt cleared on vs_rise. y=v_act_cnt during de.
// - Frame check on vs_rise: cand={h_total_cur,h_active_last,v_total_cur,v_act_cnt}.
//   valid = h_seen (>=2 hs_rise since reset/timeout) and every field nonzero.
//   valid && cand==prev -> match_cnt+1 (saturating at LOCK_FRAMES); else match_cnt=0.
//   prev<=cand always; h_total/h_active/v_total/v_active outputs <= cand.
// - FSM: UNLOCKED -> LOCKED when match_cnt reaches LOCK_FRAMES (locked=1 the following clk).
//   LOCKED -> UNLOCKED on any frame mismatch or timeout; match_cnt cleared at the same time.
// - Timeout: h_cnt==TIMEOUT_CLKS without hs_rise -> UNLOCKED, h_seen=0, measurement outputs hold.
// - visible=s_de delayed; x,y forced 0 when not visible. Pulses never stretch beyond 1 clk.
// - Coincident de_fall+hs_rise: de_fall updates land first; de_cnt still clears.
// TESTING
// - Feed generator 720p timing (1650x750, 1280x720 active): after 4th vs_rise h_total=1650,
//   h_active=1280, v_total=750, v_active=720, locked=1 one clk later (LOCK_FRAMES=2).
// - Visible pixels: first de cycle of frame -> x=0,y=0 two clks later; last -> x=1279,y=719.
// - Locked, change one line to 1651 clks -> next vs_rise gives mismatch, locked=0 next clk,
//   re-locks after LOCK_FRAMES further matching frames.
// - Stop hsync (held inactive) while locked -> locked=0 at h_cnt=4096; measurements hold.
// - Invert H_SYNC_ACTIVE=0 with inverted hsync stimulus -> identical measurements and lock.
// - Assert reset_n low mid-line -> all outputs 0 immediately (async); after release, lock
//   requires full re-acquisition (>=4 vs_rise).

Source files
------------

// File: rtl/video_timing_decoder_if.sv
// Video input bundle: sync/de stream into the decoder and the recovered coordinates/geometry.
`timescale 1ns/1ps
interface video_timing_decoder_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] x;
  logic [15:0] y;
  logic        visible;
  logic        line_start;
  logic        frame_start;
  logic [15:0] h_total;
  logic [15:0] h_active;
  logic [15:0] v_total;
  logic [15:0] v_active;
  logic        locked;

  modport master (
    output hsync, vsync, de,
    input  x, y, visible, line_start, frame_start,
    input  h_total, h_active, v_total, v_active, locked
  );

  modport slave (
    input  hsync, vsync, de,
    output x, y, visible, line_start, frame_start,
    output h_total, h_active, v_total, v_active, locked
  );
endinterface

// File: rtl/video_timing_decoder.sv
// Recovers pixel coordinates from an hsync/vsync/de stream, measures line/frame geometry and
// reports lock once the geometry repeats across consecutive frames.
`timescale 1ns/1ps
module video_timing_decoder #(
  parameter logic              H_SYNC_ACTIVE = 1'b1,
  parameter logic              V_SYNC_ACTIVE = 1'b1,
  parameter int unsigned       LOCK_FRAMES   = 2,
  parameter logic [15:0]       TIMEOUT_CLKS  = 16'd4096
) (
  input logic                   clk,
  input logic                   reset_n,
  video_timing_decoder_if.slave vid
);

  localparam logic [0:0] StUnlocked = 1'b0;
  localparam logic [0:0] StLocked   = 1'b1;
  localparam logic [7:0] LockCnt    = 8'(LOCK_FRAMES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        s_hs, s_vs, s_de, s_hs_prev, s_vs_prev, s_de_prev;
  logic        hs_rise, vs_rise, de_fall, timeout, cand_ok;
  logic [15:0] h_cnt, de_cnt, v_cnt, v_act_cnt, h_total_cur, h_active_last;
  logic [15:0] h_cnt_d, de_cnt_d, v_cnt_d, v_act_d, v_act_upd, h_total_d, h_active_d;
  logic [15:0] x_d, y_d;
  logic [1:0]  hs_seen, hs_seen_d;
  logic [7:0]  match_cnt, match_d;
  logic [63:0] prev, cand;
  logic [0:0]  state, state_d;

  // Raw sync levels are stored so an inverted-polarity input cannot fake an edge out of reset.
  assign hs_rise = (s_hs ~^ H_SYNC_ACTIVE) & ~(s_hs_prev ~^ H_SYNC_ACTIVE);
  assign vs_rise = (s_vs ~^ V_SYNC_ACTIVE) & ~(s_vs_prev ~^ V_SYNC_ACTIVE);
  assign de_fall = s_de_prev & ~s_de;

  always_comb begin
    timeout    = (h_cnt == TIMEOUT_CLKS) && !hs_rise;
    h_cnt_d    = hs_rise ? 16'd1 : sat_inc(h_cnt);
    h_total_d  = hs_rise ? h_cnt : h_total_cur;
    h_active_d = de_fall ? de_cnt : h_active_last;
    v_act_upd  = de_fall ? sat_inc(v_act_cnt) : v_act_cnt;
    v_act_d    = vs_rise ? 16'd0 : v_act_upd;

    hs_seen_d = hs_seen;
    if (timeout) begin
      hs_seen_d = 2'd0;
    end else if (hs_rise && hs_seen != 2'd2) begin
      hs_seen_d = hs_seen + 2'd1;
    end

    if (hs_rise) begin
      de_cnt_d = s_de ? 16'd1 : 16'd0;
    end else begin
      de_cnt_d = s_de ? sat_inc(de_cnt) : de_cnt;
    end

    // A coincident hsync edge is the first line of the new frame.
    if (vs_rise) begin
      v_cnt_d = hs_rise ? 16'd1 : 16'd0;
    end else begin
      v_cnt_d = hs_rise ? sat_inc(v_cnt) : v_cnt;
    end

    cand    = {h_total_d, h_active_d, v_cnt, v_act_upd};
    cand_ok = (hs_seen_d == 2'd2) && (h_total_d != 16'd0) && (h_active_d != 16'd0) &&
              (v_cnt != 16'd0) && (v_act_upd != 16'd0) && (cand == prev);

    match_d = match_cnt;
    if (timeout) begin
      match_d = 8'd0;
    end else if (vs_rise) begin
      match_d = !cand_ok ? 8'd0 : (match_cnt >= LockCnt) ? match_cnt : match_cnt + 8'd1;
    end

    state_d = state;
    if (timeout) begin
      state_d = StUnlocked;
    end else begin
      case (state)
        StUnlocked: if (match_cnt == LockCnt && !(vs_rise && !cand_ok)) state_d = StLocked;
        StLocked:   if (vs_rise && !cand_ok) state_d = StUnlocked;
        default:    state_d = StUnlocked;
      endcase
    end

    x_d = (s_de && !hs_rise) ? de_cnt : 16'd0;
    y_d = (s_de && !vs_rise) ? v_act_cnt : 16'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_hs            <= 1'b0;
      s_vs            <= 1'b0;
      s_de            <= 1'b0;
      s_hs_prev       <= 1'b0;
      s_vs_prev       <= 1'b0;
      s_de_prev       <= 1'b0;
      h_cnt           <= '0;
      de_cnt          <= '0;
      v_cnt           <= '0;
      v_act_cnt       <= '0;
      h_total_cur     <= '0;
      h_active_last   <= '0;
      hs_seen         <= '0;
      match_cnt       <= '0;
      prev            <= '0;
      state           <= StUnlocked;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.visible     <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.h_total     <= '0;
      vid.h_active    <= '0;
      vid.v_total     <= '0;
      vid.v_active    <= '0;
      vid.locked      <= 1'b0;
    end else begin
      s_hs            <= vid.hsync;
      s_vs            <= vid.vsync;
      s_de            <= vid.de;
      s_hs_prev       <= s_hs;
      s_vs_prev       <= s_vs;
      s_de_prev       <= s_de;
      h_cnt           <= h_cnt_d;
      de_cnt          <= de_cnt_d;
      v_cnt           <= v_cnt_d;
      v_act_cnt       <= v_act_d;
      h_total_cur     <= h_total_d;
      h_active_last   <= h_active_d;
      hs_seen         <= hs_seen_d;
      match_cnt       <= match_d;
      state           <= state_d;
      vid.x           <= x_d;
      vid.y           <= y_d;
      vid.visible     <= s_de;
      vid.line_start  <= hs_rise;
      vid.frame_start <= vs_rise;
      vid.locked      <= (state_d == StLocked);
      if (vs_rise) begin
        prev         <= cand;
        vid.h_total  <= h_total_d;
        vid.h_active <= h_active_d;
        vid.v_total  <= v_cnt;
        vid.v_active <= v_act_upd;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_decoder.sv
// Drives a scaled-down frame stream into a normal and an inverted-hsync decoder, scoreboarding
// per-pixel outputs and checking geometry/lock from a frame table.
`timescale 1ns/1ps
module tb_video_timing_decoder;
  localparam int HT = 50, HA = 32, HBP = 8, HSW = 4;
  localparam int VT = 20, VA = 16, VBP = 2, VSW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  video_timing_decoder_if vif ();
  video_timing_decoder_if vif_inv ();

  video_timing_decoder #(.H_SYNC_ACTIVE(1'b1)) dut (.clk(clk), .reset_n(reset_n), .vid(vif));
  video_timing_decoder #(.H_SYNC_ACTIVE(1'b0)) dut_inv (
    .clk(clk), .reset_n(reset_n), .vid(vif_inv)
  );

  typedef struct { int cyc; bit vis; int x; int y; bit ls; bit fs; } exp_t;
  typedef struct { int extra; bit chk; int ht; int ha; int vt; int va; bit lk; } frame_t;

  exp_t   q[$];
  frame_t tbl[9];
  int     total = 0, bad = 0, cyc = 0, last_hs_cyc = 0;
  bit     prev_hs = 1'b0, prev_vs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic put(input bit hs, input bit vs, input bit dv, input int xv, input int yv);
    exp_t e;
    @(negedge clk);
    vif.hsync     = hs;
    vif.vsync     = vs;
    vif.de        = dv;
    vif_inv.hsync = ~hs;
    vif_inv.vsync = vs;
    vif_inv.de    = dv;
    e.cyc = cyc;
    e.vis = dv;
    e.x   = dv ? xv : 0;
    e.y   = dv ? yv : 0;
    e.ls  = hs & ~prev_hs;
    e.fs  = vs & ~prev_vs;
    if (e.ls) last_hs_cyc = cyc;
    if (e.vis || e.ls || e.fs) q.push_back(e);
    prev_hs = hs;
    prev_vs = vs;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " zero"}, $countones({vif.x, vif.y, vif.visible, vif.line_start,
          vif.frame_start, vif.h_total, vif.h_active, vif.v_total, vif.v_active, vif.locked}), 0);
    check({tag, " zero inv"}, $countones({vif_inv.x, vif_inv.y, vif_inv.visible,
          vif_inv.line_start, vif_inv.frame_start, vif_inv.h_total, vif_inv.h_active,
          vif_inv.v_total, vif_inv.v_active, vif_inv.locked}), 0);
  endtask

  task automatic check_meas(input string tag, input frame_t f);
    check({tag, " locked"}, vif.locked, f.lk);
    check({tag, " locked inv"}, vif_inv.locked, f.lk);
    if (f.chk) begin
      check({tag, " h_total"}, vif.h_total, f.ht);
      check({tag, " h_active"}, vif.h_active, f.ha);
      check({tag, " v_total"}, vif.v_total, f.vt);
      check({tag, " v_active"}, vif.v_active, f.va);
      check({tag, " h_total inv"}, vif_inv.h_total, f.ht);
      check({tag, " v_active inv"}, vif_inv.v_active, f.va);
    end
  endtask

  // Checks the report of the previous frame three clocks after this frame's vsync edge.
  task automatic run_frame(input frame_t f, input int idx, input int abort_row);
    for (int row = 0; row < VT; row++) begin
      int len = HT + ((row == VT - 1) ? f.extra : 0);
      for (int c = 0; c < len; c++) begin
        bit dv = (row >= VBP) && (row < VBP + VA) && (c >= HBP) && (c < HBP + HA);
        if (row == abort_row && c == 20) return;
        put(c < HSW, row < VSW, dv, c - HBP, row - VBP);
        if (row == 0 && c == 3) check_meas($sformatf("frame%0d", idx), f);
      end
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < 9; i++) run_frame(tbl[i], i, -1);
  endtask

  // Per-cycle scoreboard: an entry pushed at drive cycle k must appear at cycle k+2.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc + 2 < cyc) begin
      total++;
      bad++;
      $display("FAIL scoreboard stale: entry for cycle %0d unconsumed at %0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    e = '{default: 0};
    if (q.size() > 0 && q[0].cyc + 2 == cyc) e = q.pop_front();
    check("visible", vif.visible, e.vis);
    check("x", vif.x, e.x);
    check("y", vif.y, e.y);
    check("line_start", vif.line_start, e.ls);
    check("frame_start", vif.frame_start, e.fs);
    check("visible inv", vif_inv.visible, e.vis);
    check("x inv", vif_inv.x, e.x);
    check("y inv", vif_inv.y, e.y);
    check("line_start inv", vif_inv.line_start, e.ls);
    check("frame_start inv", vif_inv.frame_start, e.fs);
  end

  initial begin
    int drop_cyc = -1;
    tbl[0] = '{0, 1'b0, 0, 0, 0, 0, 1'b0};
    tbl[1] = '{0, 1'b1, HT, HA, VT, VA, 1'b0};
    tbl[2] = '{0, 1'b1, HT, HA, VT, VA, 1'b0};
    tbl[3] = '{0, 1'b1, HT, HA, VT, VA, 1'b1};
    tbl[4] = '{1, 1'b1, HT, HA, VT, VA, 1'b1};
    tbl[5] = '{0, 1'b1, HT + 1, HA, VT, VA, 1'b0};
    tbl[6] = '{0, 1'b1, HT, HA, VT, VA, 1'b0};
    tbl[7] = '{0, 1'b1, HT, HA, VT, VA, 1'b0};
    tbl[8] = '{0, 1'b1, HT, HA, VT, VA, 1'b1};

    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.de = 1'b0;
    vif_inv.hsync = 1'b1; vif_inv.vsync = 1'b0; vif_inv.de = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2 reset_n = 1'b1;
    repeat (4) put(0, 0, 0, 0, 0);

    run_table();

    // Hsync stops while locked: lock must drop, measurements hold.
    for (int i = 0; i < 6000; i++) begin
      put(0, 0, 0, 0, 0);
      if (!vif.locked) begin
        drop_cyc = cyc;
        break;
      end
    end
    check("timeout drop cycle", drop_cyc - last_hs_cyc, 4098);
    check("timeout locked inv", vif_inv.locked, 0);
    check("timeout hold h_total", vif.h_total, HT);
    check("timeout hold h_active", vif.h_active, HA);
    check("timeout hold v_total", vif.v_total, VT);
    check("timeout hold v_active", vif.v_active, VA);

    // Reset in the middle of a visible line.
    run_frame(tbl[0], 99, VBP + 3);
    check("pre-reset visible", vif.visible, 1);
    #2 reset_n = 1'b0;
    q.delete();
    #1 check_zero("async reset");
    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.de = 1'b0;
    vif_inv.hsync = 1'b1; vif_inv.vsync = 1'b0; vif_inv.de = 1'b0;
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("held reset");
    #2 reset_n = 1'b1;
    repeat (4) put(0, 0, 0, 0, 0);

    run_table();
    repeat (4) put(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
